// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, requester
// port indices and default bus widths.
// Build option: SRAM_ARB_WB_PORT_EN enables the Wishbone debug port (port 2).
package sram_arb_pkg;

  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned NREQ_DEF = 3;

  // Requester port indices
  localparam int unsigned QCPU    = 0;
  localparam int unsigned MC14500 = 1;
  localparam int unsigned WB      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Width of a port index; never below one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req_i       - request vector, one bit per port
//   last_i      - index of the most recently granted port
//   win_idx_c_o - winning port index (first requester after last_i, wrapping)
//   win_vld_c_o - high when any request is present
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] win_idx_c_o,
  output logic          win_vld_c_o
);

  int unsigned idx_c;

  // Scan ports last+1 .. last+N (mod N); first hit wins
  always_comb begin
    win_idx_c_o = last_i;
    win_vld_c_o = 1'b0;
    idx_c       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx_c = (32'(last_i) + i) % N;
      if (!win_vld_c_o && req_i[idx_c]) begin
        win_vld_c_o = 1'b1;
        win_idx_c_o = IW'(idx_c);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between requesters
// (port 0 qcpu, port 1 mc14500, port 2 Wishbone debug).
// Build option: SRAM_ARB_WB_PORT_EN -- when defined NREQ is a parameter
// (default 3); when undefined NREQ is fixed to 2 and port 2 does not exist.
// Ports:
//   wb_clk_i, rst_n          - clock, async active-low reset
//   req_i/we_i               - per-port request and write enable
//   addr_i/wdata_i           - per-port address/data, port k at [k*W +: W]
//   gnt_o                    - one-cycle pulse when a port's access issues
//   rvalid_o/rdata_o         - read response pulse and shared read data
//   sram_cen_n/sram_gwen_n   - SRAM chip / write enable, active-low
//   sram_addr/sram_din       - SRAM address and write data
//   sram_dout                - SRAM read data, one cycle after the read
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
`ifdef SRAM_ARB_WB_PORT_EN
  parameter int unsigned NREQ = NREQ_DEF
`else
  localparam int unsigned NREQ = 2
`endif
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               sram_cen_n,
  output logic               sram_gwen_n,
  output logic [AW-1:0]      sram_addr,
  output logic [DW-1:0]      sram_din,
  input  logic [DW-1:0]      sram_dout
);

  localparam int unsigned IW = idx_w(NREQ);

  arb_state_t state_q, state_d;

  logic [IW-1:0]   ptr_q, ptr_d;      // next port to get priority
  logic [IW-1:0]   win_q, win_d;
  logic            we_q, we_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            cen_q, cen_d;
  logic            gwen_q, gwen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [IW-1:0]   last_c;
  logic [IW-1:0]   pick_win_c;
  logic            pick_vld_c;

  // Selector searches after "last"; port before ptr acts as last grant
  assign last_c = (ptr_q == '0) ? IW'(NREQ - 1) : ptr_q - IW'(1);

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i       (req_i),
    .last_i      (last_c),
    .win_idx_c_o (pick_win_c),
    .win_vld_c_o (pick_vld_c)
  );

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      cen_q    <= 1'b1;
      gwen_q   <= 1'b1;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      cen_q    <= cen_d;
      gwen_q   <= gwen_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state: arbitration in IDLE, pointer advances on the grant cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          state_d = ACCESS;
          win_d   = pick_win_c;
          we_d    = we_i[pick_win_c];
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RESP;
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values: loaded one edge ahead so they are live in the
  // ACCESS cycle (SRAM strobes, gnt) and in the IDLE cycle after RESP (rvalid)
  always_comb begin
    gnt_d    = '0;
    rvalid_d = '0;
    cen_d    = 1'b1;
    gwen_d   = 1'b1;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          gnt_d  = NREQ'(1) << pick_win_c;
          cen_d  = 1'b0;
          gwen_d = ~we_i[pick_win_c];
          addr_d = addr_i[32'(pick_win_c) * AW +: AW];
          din_d  = wdata_i[32'(pick_win_c) * DW +: DW];
        end
      end
      RESP: begin
        rdata_d  = sram_dout;
        rvalid_d = NREQ'(1) << win_q;
      end
      default: begin
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign sram_cen_n  = cen_q;
  assign sram_gwen_n = gwen_q;
  assign sram_addr   = addr_q;
  assign sram_din    = din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural single-port SRAM.
// Honors SRAM_ARB_WB_PORT_EN to match the DUT's port count.
module tb_sram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
`ifdef SRAM_ARB_WB_PORT_EN
  localparam int unsigned NREQ = 3;
`else
  localparam int unsigned NREQ = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr_v;
  logic [NREQ*DW-1:0] wdata_v;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               cen_n;
  logic               gwen_n;
  logic [AW-1:0]      saddr;
  logic [DW-1:0]      sdin;
  logic [DW-1:0]      sdout;

  logic [DW-1:0]      mem [64];

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int hit_cnt = 0;
  logic [NREQ-1:0] gq[$];
  int gcyc[$];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .wb_clk_i    (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr_v),
    .wdata_i     (wdata_v),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .sram_cen_n  (cen_n),
    .sram_gwen_n (gwen_n),
    .sram_addr   (saddr),
    .sram_din    (sdin),
    .sram_dout   (sdout)
  );

  // SRAM model: read data appears the cycle after the enable
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!cen_n) begin
      if (!gwen_n) mem[saddr] <= sdin;
      else         sdout      <= mem[saddr];
    end
  end

  // Grant / response / address-hit log, sampled mid-cycle
  always @(negedge clk) begin
    if (gnt != '0) begin
      gq.push_back(gnt);
      gcyc.push_back(cyc);
    end
    if (rvalid != '0) rv_cnt++;
    if (!cen_n && saddr == 6'h2A) hit_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req[k] = 1'b1;
    we[k]  = w;
    addr_v[k*AW +: AW] = a;
    wdata_v[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int gbase, hbase, rbase, ng;

  initial begin
    rst_n = 1'b0;
    req = '0;
    we = '0;
    addr_v = '0;
    wdata_v = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_cen", 32'(cen_n), 1);
    chk("rst_gwen", 32'(gwen_n), 1);
    chk("rst_addr", 32'(saddr), 0);
    chk("rst_din", 32'(sdin), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst_n = 1'b1;
    tick();

    // Port 0 write then read back
    set_port(0, 1'b1, 6'h05, 8'hA5);
    tick();
    chk("wr_gnt", 32'(gnt), 1);
    chk("wr_cen", 32'(cen_n), 0);
    chk("wr_gwen", 32'(gwen_n), 0);
    chk("wr_addr", 32'(saddr), 32'h05);
    chk("wr_din", 32'(sdin), 32'hA5);
    req = '0;
    tick();
    chk("wr_idle_gnt", 32'(gnt), 0);
    chk("wr_idle_cen", 32'(cen_n), 1);
    set_port(0, 1'b0, 6'h05, 8'h00);
    tick();
    chk("rd_gnt", 32'(gnt), 1);
    chk("rd_gwen", 32'(gwen_n), 1);
    chk("rd_addr", 32'(saddr), 32'h05);
    req = '0;
    tick();
    chk("rd_resp_rvalid", 32'(rvalid), 0);
    chk("rd_resp_cen", 32'(cen_n), 1);
    tick();
    chk("rd_rvalid", 32'(rvalid), 1);
    chk("rd_rdata", 32'(rdata), 32'hA5);
    tick();
    chk("rd_rvalid_end", 32'(rvalid), 0);
    chk("rd_rdata_hold", 32'(rdata), 32'hA5);

    // All ports hold write requests: strict rotation, 2 cycles apart
    do_reset();
    gbase = gq.size();
    for (int k = 0; k < NREQ; k++) set_port(k, 1'b1, 6'(32'h10 + k), 8'(32'h50 + k));
    for (int i = 0; i < 4 * NREQ; i++) tick();
    req = '0;
    tick();
    tick();
    ng = gq.size() - gbase;
    chk("rr_count", 32'(ng), 2 * NREQ);
    if (ng > 2 * NREQ) ng = 2 * NREQ;
    for (int i = 0; i < ng; i++) begin
      chk("rr_order", 32'(gq[gbase + i]), 32'(1) << (i % NREQ));
      if (i > 0) chk("rr_gap", 32'(gcyc[gbase + i] - gcyc[gbase + i - 1]), 2);
    end
    for (int k = 0; k < NREQ; k++) chk("rr_mem", 32'(mem[32'h10 + k]), 32'h50 + k);

    // Port 1 withdraws while port 0 is serviced
    do_reset();
    gbase = gq.size();
    hbase = hit_cnt;
    set_port(0, 1'b1, 6'h07, 8'h3C);
    set_port(1, 1'b0, 6'h2A, 8'h00);
    tick();
    chk("wd_gnt", 32'(gnt), 1);
    req = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("wd_ngrants", 32'(gq.size() - gbase), 1);
    chk("wd_no_access", 32'(hit_cnt - hbase), 0);
    chk("wd_mem", 32'(mem[7]), 32'h3C);

    // Reset during RESP of the highest port's read
    do_reset();
    rbase = rv_cnt;
    set_port(NREQ - 1, 1'b0, 6'h05, 8'h00);
    tick();
    chk("ab_gnt", 32'(gnt), 32'(1) << (NREQ - 1));
    req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("ab_rst_cen", 32'(cen_n), 1);
    chk("ab_rst_rvalid", 32'(rvalid), 0);
    chk("ab_rst_rdata", 32'(rdata), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ab_no_rvalid", 32'(rv_cnt - rbase), 0);
    chk("ab_rdata", 32'(rdata), 0);
    chk("ab_cen", 32'(cen_n), 1);
    for (int k = 0; k < NREQ; k++) set_port(k, 1'b1, 6'(32'h20 + k), 8'(32'h60 + k));
    tick();
    chk("ab_first_gnt", 32'(gnt), 1);
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be AW, default 6, SRAM address width; DW, default 8, SRAM data width; NREQ, default 3, number of requester ports.
REQ-002 wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  NREQ  per-port access request, held by requester until gnt_o.
REQ-005 we_i  input  NREQ  per-port write enable, sampled with req_i.
REQ-006 addr_i  input  NREQ*AW  per-port address, port k at bits [k*AW +: AW].
REQ-007 wdata_i  input  NREQ*DW  per-port write data, same packing.
REQ-008 gnt_o  output  NREQ  one-cycle pulse: port's access issued this cycle.
REQ-009 rvalid_o  output  NREQ  one-cycle pulse: rdata_o valid for that port.
REQ-010 rdata_o  output  DW  read data shared by all ports, qualified by rvalid_o.
REQ-011 sram_cen_n  output  1  SRAM chip enable, active-low.
REQ-012 sram_gwen_n  output  1  SRAM global write enable, active-low.
REQ-013 sram_addr  output  AW  SRAM address.
REQ-014 sram_din  output  DW  SRAM write data.
REQ-015 sram_dout  input  DW  SRAM read data, valid one cycle after a read with sram_cen_n low.
REQ-016 Port mapping SHALL be: port 0 qcpu, port 1 mc14500, port 2 Wishbone debug.

Function
REQ-017 FSM SHALL have states IDLE, ACCESS and RESP.
REQ-018 In IDLE with any req_i bit set, the block SHALL select a winner round-robin, starting at the port after the last granted port, register winner index, address, data and we, and go to ACCESS.
REQ-019 In ACCESS, the block SHALL drive sram_cen_n=0, sram_gwen_n=~we, sram_addr and sram_din from the registered values, and pulse gnt_o[winner] for exactly this cycle.
REQ-020 After ACCESS, a write SHALL return to IDLE and a read SHALL go to RESP.
REQ-021 In RESP, the block SHALL register sram_dout into rdata_o, pulse rvalid_o[winner] in the following cycle (the IDLE cycle), and return to IDLE.
REQ-022 Latency SHALL be as follows: with req sampled in cycle N, gnt_o is at N+1; read rvalid_o is at N+3 (2 cycles after gnt_o); throughput is one write per 2 cycles or one read per 3 cycles.
REQ-023 rdata_o SHALL hold its last value until the next read completes.
REQ-024 The round-robin pointer SHALL update only on grant, so no requester waits more than NREQ-1 other accesses.
REQ-025 A req_i deasserted before gnt_o SHALL be withdrawn, and no SRAM access SHALL occur for it; a req_i deasserted after arbitration SHALL still complete.
REQ-026 A port holding req_i through its gnt_o cycle SHALL be re-arbitrated as a new request from the next IDLE.
REQ-027 Outside ACCESS, sram_cen_n SHALL be 1, sram_gwen_n 1, gnt_o 0, and rvalid_o 0 except the single pulse cycle.

Reset
REQ-028 On rst_n low, the FSM SHALL go to IDLE, set the pointer to port 0, set gnt_o and rvalid_o to 0, set sram_cen_n and sram_gwen_n to 1, and clear sram_addr, sram_din and rdata_o, all asynchronously.
REQ-029 Reset during ACCESS or RESP SHALL abort the access without issuing a late gnt_o or rvalid_o after release.

Configuration
REQ-030 With macro SRAM_ARB_WB_PORT_EN defined, port 2 SHALL be a full requester.
REQ-031 Without SRAM_ARB_WB_PORT_EN, NREQ SHALL be forced to 2, port 2 signals SHALL be absent, and round-robin SHALL cover ports 0 and 1 only.

Structure
REQ-032 Shared package sram_arb_pkg SHALL hold the FSM state enum, port index constants (QCPU=0, MC14500=1, WB=2) and default widths.
REQ-033 The round-robin selector SHALL be sub-module rr_pick, which is combinational: inputs request vector and last-grant index; output winner index and valid.

Verification
REQ-034 Port 0 write addr 0x05 data 0xA5, then port 0 read addr 0x05 -> gnt_o[0] at N+1 each time, rvalid_o[0] 2 cycles after the read grant with rdata_o=0xA5.
REQ-035 Ports 0, 1 and 2 request together and hold -> grants in order 0,1,2,0,1,2; no port is granted twice before the others.
REQ-036 Port 1 asserts req for one cycle, then drops it while port 0 is being serviced -> no gnt_o[1] and no SRAM access at port 1's address.
REQ-037 rst_n pulsed low during RESP of a port 2 read -> no rvalid_o after release, sram_cen_n=1, and the next grant goes to port 0 first.
REQ-038 Build without SRAM_ARB_WB_PORT_EN, with ports 0 and 1 requesting continuously -> grants alternate 0,1,0,1, each write 2 cycles apart.
